rr_token_arbiter: RTL and testbench

//  Round-robin arbiter for one shared resource among N requesters.
//  A one-hot token rotates around a ring of slots. Each slot is one requester.
//  A requester is granted only while the token sits on its slot.
//  GNT drives the resource select; GNT_ID is the binary form of the grant for the resource mux.

---
 rtl/rr_arb_pkg.sv | 17 +
 rtl/rr_token_arbiter_onehot_to_bin.sv | 17 +
 rtl/rr_token_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_token_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared states and defaults for the round-robin token arbiter
package rr_arb_pkg;

   typedef enum logic [1:0] {
      SCAN    = 2'b00,
      GRANT   = 2'b01,
      RELEASE = 2'b10
   } arb_state_t;

   localparam int DEF_N        = 16;
   localparam int DEF_IDW      = 4;
   localparam int DEF_MAX_HOLD = 8;

   // Token starts on slot 0, which is the leftmost bit of a [0:N-1] vector.
   localparam logic [0:DEF_N-1] DEF_RST_TOKEN = 16'h8000;

endpackage

// File: rtl/rr_token_arbiter_onehot_to_bin.sv
// rtl/rr_token_arbiter_onehot_to_bin.sv - OR-tree one-hot to binary encoder (bin[0] is MSB)
module onehot_to_bin #(
   parameter int N   = 16,
   parameter int IDW = 4
) (
   input  logic [0:N-1]   oh,
   output logic [0:IDW-1] bin
);

   always_comb begin
      bin = '0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) bin = bin | IDW'(i);
      end
   end

endmodule

// File: rtl/rr_token_arbiter.sv
// rtl/rr_token_arbiter.sv - round-robin token arbiter; define PRIORITY_SKIP_EN to let
// an idle SCAN jump the token straight to the next requesting slot.
module rr_token_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int IDW      = DEF_IDW,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           EN,
   input  logic [0:N-1]   REQ,
   output logic [0:N-1]   GNT,
   output logic [0:IDW-1] GNT_ID,
   output logic           GNT_VLD,
   output logic [0:N-1]   TOKEN,
   output logic           PREEMPT
);

   localparam int               HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCW-1:0]   HOLD_LAST = HCW'(MAX_HOLD - 1);
   localparam logic [0:N-1]     TOKEN_RST = {1'b1, {(N-1){1'b0}}};

   arb_state_t     state, state_nxt;
   logic [0:N-1]   token_nxt, gnt_nxt, step_tok, scan_tok;
   logic [0:IDW-1] tok_id, gnt_id_nxt;
   logic           gnt_vld_nxt, preempt_nxt, tok_req;
   logic [HCW-1:0] hold_cnt, hold_cnt_nxt;

   // One encoder on the token serves both GNT_ID and the skip-search origin.
   onehot_to_bin #(.N(N), .IDW(IDW)) u_enc (
      .oh  (TOKEN),
      .bin (tok_id)
   );

   assign tok_req  = |(REQ & TOKEN);
   assign step_tok = {TOKEN[N-1], TOKEN[0:N-2]};

`ifdef PRIORITY_SKIP_EN
   logic [IDW-1:0] cand;
   logic           found;

   always_comb begin
      scan_tok = TOKEN;
      found    = 1'b0;
      cand     = '0;
      for (int k = 1; k < N; k++) begin
         cand = tok_id + IDW'(k);
         if (!found && REQ[cand]) begin
            found          = 1'b1;
            scan_tok       = '0;
            scan_tok[cand] = 1'b1;
         end
      end
   end
`else
   assign scan_tok = step_tok;
`endif

   always_comb begin
      state_nxt    = state;
      token_nxt    = TOKEN;
      gnt_nxt      = GNT;
      gnt_id_nxt   = GNT_ID;
      gnt_vld_nxt  = GNT_VLD;
      preempt_nxt  = 1'b0;
      hold_cnt_nxt = hold_cnt;
      case (state)
         SCAN: begin
            if (tok_req) begin
               state_nxt    = GRANT;
               gnt_nxt      = TOKEN;
               gnt_id_nxt   = tok_id;
               gnt_vld_nxt  = 1'b1;
               hold_cnt_nxt = '0;
            end else begin
               token_nxt = scan_tok;
            end
         end
         GRANT: begin
            hold_cnt_nxt = hold_cnt + HCW'(1);
            if (!tok_req || hold_cnt == HOLD_LAST) begin
               state_nxt   = RELEASE;
               gnt_nxt     = '0;
               gnt_id_nxt  = '0;
               gnt_vld_nxt = 1'b0;
               preempt_nxt = tok_req;
            end
         end
         RELEASE: begin
            state_nxt = SCAN;
            token_nxt = step_tok;
         end
         default: begin
            state_nxt    = SCAN;
            gnt_nxt      = '0;
            gnt_id_nxt   = '0;
            gnt_vld_nxt  = 1'b0;
            hold_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= SCAN;
         TOKEN    <= TOKEN_RST;
         GNT      <= '0;
         GNT_ID   <= '0;
         GNT_VLD  <= 1'b0;
         PREEMPT  <= 1'b0;
         hold_cnt <= '0;
      end else if (EN) begin
         state    <= state_nxt;
         TOKEN    <= token_nxt;
         GNT      <= gnt_nxt;
         GNT_ID   <= gnt_id_nxt;
         GNT_VLD  <= gnt_vld_nxt;
         PREEMPT  <= preempt_nxt;
         hold_cnt <= hold_cnt_nxt;
      end else begin
         PREEMPT  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_token_arbiter.sv
// tb/tb_rr_token_arbiter.sv - scoreboard bench for rr_token_arbiter against a slot-index model
module tb_rr_token_arbiter;

   localparam int N  = 16;
   localparam int MH = 8;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           EN  = 1'b0;
   logic [0:N-1]   REQ = '0;
   logic [0:N-1]   GNT, TOKEN;
   logic [0:3]     GNT_ID;
   logic           GNT_VLD, PREEMPT;

   rr_token_arbiter #(.N(N), .IDW(4), .MAX_HOLD(MH)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .REQ     (REQ),
      .GNT     (GNT),
      .GNT_ID  (GNT_ID),
      .GNT_VLD (GNT_VLD),
      .TOKEN   (TOKEN),
      .PREEMPT (PREEMPT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [0:N-1] tok;
      logic [0:N-1] gnt;
      logic [3:0]   id;
      logic         vld;
      logic         pre;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   ncmp  = 0;
   int   nfail = 0;

   // Model: token as a slot number, current grantee (-1 = none), edges spent granted.
   int   m_tok  = 0;
   int   m_gnt  = -1;
   int   m_held = 0;
   bit   m_rel  = 1'b0;
   bit   m_pre  = 1'b0;

   function automatic logic [0:N-1] slot_vec(int s);
      logic [0:N-1] v;
      v = '0;
      if (s >= 0) v[s] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      ncmp++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit en, input logic [0:N-1] req);
      int  nxt;
      bit  hit;
      if (rst) begin
         m_tok = 0; m_gnt = -1; m_held = 0; m_rel = 1'b0; m_pre = 1'b0;
      end else if (!en) begin
         m_pre = 1'b0;
      end else begin
         m_pre = 1'b0;
         if (m_gnt >= 0) begin
            m_held++;
            if (!req[m_gnt]) begin
               m_gnt = -1; m_rel = 1'b1;
            end else if (m_held == MH) begin
               m_gnt = -1; m_rel = 1'b1; m_pre = 1'b1;
            end
         end else if (m_rel) begin
            m_rel = 1'b0;
            m_tok = (m_tok + 1) % N;
         end else if (req[m_tok]) begin
            m_gnt  = m_tok;
            m_held = 0;
         end else begin
`ifdef PRIORITY_SKIP_EN
            hit = 1'b0;
            nxt = m_tok;
            for (int k = 1; k < N; k++) begin
               if (!hit && req[(m_tok + k) % N]) begin
                  hit = 1'b1;
                  nxt = (m_tok + k) % N;
               end
            end
            m_tok = nxt;
`else
            hit   = 1'b0;
            nxt   = (m_tok + 1) % N;
            m_tok = hit ? m_tok : nxt;
`endif
         end
      end
   endtask

   task automatic cycle(input bit rst, input bit en, input logic [0:N-1] req);
      exp_t e;
      @(negedge CLK);
      RST = rst;
      EN  = en;
      REQ = req;
      model_step(rst, en, req);
      e.tok = slot_vec(m_tok);
      e.gnt = slot_vec(m_gnt);
      e.id  = (m_gnt >= 0) ? 4'(m_gnt) : 4'd0;
      e.vld = (m_gnt >= 0);
      e.pre = m_pre;
      q.push_back(e);
   endtask

   always @(posedge CLK) begin
      #2;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("token",   32'(TOKEN),   32'(mon_e.tok));
         chk("gnt",     32'(GNT),     32'(mon_e.gnt));
         chk("gnt_id",  32'(GNT_ID),  32'(mon_e.id));
         chk("gnt_vld", 32'(GNT_VLD), 32'(mon_e.vld));
         chk("preempt", 32'(PREEMPT), 32'(mon_e.pre));
      end
   end

   initial begin
      logic [0:N-1] r;
      int           guard;

      // reset for two edges, EN low to show reset overrides it
      cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, '0);

      // single requester on slot 5: walk, 8-cycle hold, preempt, release
      r = slot_vec(5);
      for (int i = 0; i < 22; i++) cycle(1'b0, 1'b1, r);
      cycle(1'b0, 1'b1, '0);

      // slot 3 drops its request after 3 granted cycles
      cycle(1'b1, 1'b1, '0);
      r = slot_vec(3);
      guard = 0;
      do begin
         cycle(1'b0, 1'b1, r);
         guard++;
      end while (!(m_gnt == 3 && m_held == 2) && guard < 40);
      chk("slot3_grant_reached", 32'(guard < 40), 32'd1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0);

      // everybody requesting: full rotation with wrap
      cycle(1'b1, 1'b1, '0);
      for (int i = 0; i < N * (MH + 2) + 12; i++) cycle(1'b0, 1'b1, '1);

      // freeze mid-grant, then reset mid-grant
      cycle(1'b1, 1'b1, '0);
      r = slot_vec(0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, r);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, r);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, r);
      cycle(1'b1, 1'b1, r);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);

      // lone far requester and no-request idle (token jump vs. step)
      r = slot_vec(12);
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, r);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0);

      // randomized dense traffic with stalls and rare resets
      r = '0;
      for (int i = 0; i < 1500; i++) begin
         for (int s = 0; s < N; s++) begin
            if (r[s]) r[s] = ($urandom_range(0, 5) != 0);
            else      r[s] = ($urandom_range(0, 3) == 0);
         end
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, r);
      end

      // randomized sparse traffic
      r = '0;
      for (int i = 0; i < 500; i++) begin
         for (int s = 0; s < N; s++) begin
            if (r[s]) r[s] = ($urandom_range(0, 7) != 0);
            else      r[s] = ($urandom_range(0, 39) == 0);
         end
         cycle(1'b0, $urandom_range(0, 7) != 0, r);
      end

      @(posedge CLK);
      #3;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
